// File: rtl/ti_roic_reg_spi_master.sv
// SPI master for the TI ROIC configuration port: one 24-bit frame per write
// request ({addr[7:0], data[15:0]}, MSB first), with 16-bit readback capture.
module ti_roic_reg_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic        clk_20mhz,
  input  logic        rst_n_20mhz,
  input  logic        wr_req,
  input  logic [15:0] reg_addr,
  input  logic [15:0] reg_data,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [15:0] rd_data,
  output logic        roic_sclk,
  output logic        roic_sen,
  output logic        roic_sdata,
  input  logic        roic_sdout
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

  state_t      state;
  logic [23:0] shreg;
  logic [15:0] cap;
  logic [15:0] cnt;
  logic [4:0]  bit_cnt;

  // The ROIC register space is 8 bits wide; the upper address byte is dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^reg_addr[15:8];

  always_ff @(posedge clk_20mhz) begin
    if (!rst_n_20mhz) begin
      // NOTE: every register, including the shift and capture registers, is
      // reset so a mid-frame reset leaves no stale readback behind.
      state      <= IDLE;
      shreg      <= '0;
      cap        <= '0;
      cnt        <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      rd_data    <= '0;
      roic_sclk  <= 1'b0;
      roic_sen   <= 1'b1;
      roic_sdata <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; pulses default low here and
      // are overridden further down in the same block.
      done    <= 1'b0;
      overrun <= wr_req && (state != IDLE);

      case (state)
        IDLE: begin
          if (wr_req) begin
            shreg      <= {reg_addr[7:0], reg_data};
            roic_sdata <= reg_addr[7];
            roic_sen   <= 1'b0;
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!roic_sclk) begin
              // Shifting on every rise leaves exactly the data-phase bits
              // (frame bits 8..23) in the 16-bit capture register.
              roic_sclk <= 1'b1;
              cap       <= {cap[14:0], roic_sdout};
            end else begin
              roic_sclk <= 1'b0;
              if (bit_cnt == 5'd23) begin
                roic_sdata <= 1'b0;
                state      <= HOLD;
              end else begin
                shreg      <= {shreg[22:0], 1'b0};
                roic_sdata <= shreg[22];
                bit_cnt    <= bit_cnt + 5'd1;
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt      <= '0;
            roic_sen <= 1'b1;
            state    <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        GAP: begin
          if (cnt == IDLE_LAST) begin
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            rd_data <= cap;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ti_roic_reg_spi_master.sv
// Self-checking bench: a cycle-indexed frame-timeline model predicts every
// output of two DUT instances (default timing and all-minimum timing).
module tb_ti_roic_reg_spi_master;

  localparam int NI = 2;

  function automatic int p_div(input int i);  return (i == 0) ? 4 : 1; endfunction
  function automatic int p_set(input int i);  return (i == 0) ? 2 : 1; endfunction
  function automatic int p_hold(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int p_idle(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int flen(input int i);
    return 1 + p_set(i) + 48 * p_div(i) + p_hold(i) + p_idle(i);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [NI];
  logic        wr_req   [NI];
  logic [15:0] reg_addr [NI];
  logic [15:0] reg_data [NI];
  logic        sdout    [NI] = '{1'b0, 1'b0};
  logic        busy     [NI];
  logic        done     [NI];
  logic        overrun  [NI];
  logic [15:0] rd_data  [NI];
  logic        sclk     [NI];
  logic        sen      [NI];
  logic        sdata    [NI];

  ti_roic_reg_spi_master u0 (
    .clk_20mhz(clk), .rst_n_20mhz(rst_n[0]), .wr_req(wr_req[0]),
    .reg_addr(reg_addr[0]), .reg_data(reg_data[0]), .busy(busy[0]),
    .done(done[0]), .overrun(overrun[0]), .rd_data(rd_data[0]),
    .roic_sclk(sclk[0]), .roic_sen(sen[0]), .roic_sdata(sdata[0]),
    .roic_sdout(sdout[0])
  );

  ti_roic_reg_spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u1 (
    .clk_20mhz(clk), .rst_n_20mhz(rst_n[1]), .wr_req(wr_req[1]),
    .reg_addr(reg_addr[1]), .reg_data(reg_data[1]), .busy(busy[1]),
    .done(done[1]), .overrun(overrun[1]), .rd_data(rd_data[1]),
    .roic_sclk(sclk[1]), .roic_sen(sen[1]), .roic_sdata(sdata[1]),
    .roic_sdout(sdout[1])
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, want);
    end
  endtask

  // Model state: cycle c ends at posedge; a frame accepted at the edge ending
  // cycle n0 occupies cycles n0+1 .. n0+flen, with done in cycle n0+flen.
  int          cyc = 0;
  bit          live     [NI] = '{1'b0, 1'b0};
  bit          active   [NI] = '{1'b0, 1'b0};
  int          n0       [NI];
  int          ov_cyc   [NI] = '{-1, -1};
  logic [23:0] frame    [NI];
  logic [23:0] pat      [NI];
  logic [23:0] next_pat [NI];
  logic [15:0] prev_rd  [NI];

  function automatic bit m_busy(input int i, input int c);
    return active[i] && (c - n0[i] >= 1) && (c - n0[i] <= flen(i) - 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n[i]) begin
        live[i]    = 1'b1;
        active[i]  = 1'b0;
        prev_rd[i] = '0;
        ov_cyc[i]  = -1;
      end else if (wr_req[i]) begin
        if (m_busy(i, cyc)) begin
          ov_cyc[i] = cyc + 1;
        end else begin
          if (active[i]) prev_rd[i] = pat[i][15:0];
          active[i] = 1'b1;
          n0[i]     = cyc;
          frame[i]  = {reg_addr[i][7:0], reg_data[i]};
          pat[i]    = next_pat[i];
        end
      end
    end
    cyc++;
  end

  // ROIC readback model: during bit r of the frame it presents pat[23-r].
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NI; i++) begin
      int k, s, d;
      k = cyc - n0[i];
      s = p_set(i);
      d = p_div(i);
      if (active[i] && k > s && k <= s + 48 * d)
        sdout[i] = pat[i][23 - (k - 1 - s) / (2 * d)];
      else
        sdout[i] = 1'($urandom_range(1, 0));
    end
  end

  task automatic expect_outs(input int i, input int c,
                             output logic e_busy, output logic e_done,
                             output logic e_sen, output logic e_sclk,
                             output logic e_sdata, output logic [15:0] e_rd);
    int k, s, d, h, j;
    s = p_set(i); d = p_div(i); h = p_hold(i);
    e_busy = 1'b0; e_done = 1'b0; e_sen = 1'b1; e_sclk = 1'b0; e_sdata = 1'b0;
    e_rd = prev_rd[i];
    if (active[i]) begin
      k = c - n0[i];
      if (k >= flen(i)) begin
        e_rd   = pat[i][15:0];
        e_done = (k == flen(i));
      end else if (k >= 1) begin
        e_busy = 1'b1;
        e_sen  = (k > s + 48 * d + h);
        if (k <= s) begin
          e_sdata = frame[i][23];
        end else if (k <= s + 48 * d) begin
          j       = k - 1 - s;
          e_sclk  = 1'((j / d) % 2);
          e_sdata = frame[i][23 - j / (2 * d)];
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic eb, ed, es, ec, ex;
      logic [15:0] er;
      if (live[i]) begin
        expect_outs(i, cyc, eb, ed, es, ec, ex, er);
        check($sformatf("u%0d.busy", i),       busy[i],    eb);
        check($sformatf("u%0d.done", i),       done[i],    ed);
        check($sformatf("u%0d.overrun", i),    overrun[i], (cyc == ov_cyc[i]));
        check($sformatf("u%0d.roic_sen", i),   sen[i],     es);
        check($sformatf("u%0d.roic_sclk", i),  sclk[i],    ec);
        check($sformatf("u%0d.roic_sdata", i), sdata[i],   ex);
        check($sformatf("u%0d.rd_data", i),    rd_data[i], er);
      end
    end
  end

  // Wire-level receiver: what the ROIC latches on each SCLK rise.
  logic [23:0] rx     [NI] = '{24'h0, 24'h0};
  int          rises  [NI] = '{0, 0};
  bit          p_sclk [NI] = '{1'b0, 1'b0};
  bit          p_sen  [NI] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (p_sen[i] && sen[i] === 1'b0) begin
        rx[i]    = '0;
        rises[i] = 0;
      end
      if (sclk[i] === 1'b1 && !p_sclk[i]) begin
        rx[i] = {rx[i][22:0], sdata[i]};
        rises[i]++;
      end
      p_sclk[i] = (sclk[i] === 1'b1);
      p_sen[i]  = (sen[i] !== 1'b0);
    end
  end

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] d,
                      input logic [23:0] p, output int n);
    reg_addr[i] = a;
    reg_data[i] = d;
    next_pat[i] = p;
    wr_req[i]   = 1'b1;
    n           = cyc;
    @(posedge clk);
    #1;
    wr_req[i] = 1'b0;
  endtask

  task automatic random_frames(input int i, input int count);
    int n, dummy, gap;
    for (int f = 0; f < count; f++) begin
      send(i, 16'($urandom), 16'($urandom), 24'($urandom), n);
      if ($urandom_range(1, 0) == 1) begin
        goto(n + int'($urandom_range(flen(i) - 1, 1)));
        send(i, 16'($urandom), 16'($urandom), 24'($urandom), dummy);
      end
      gap = int'($urandom_range(6, 0));
      goto(n + flen(i) + gap);
    end
  endtask

  initial begin
    int n, m, n2, q, f, dummy;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; wr_req[i] = 1'b0; reg_addr[i] = '0; reg_data[i] = '0;
      next_pat[i] = '0;
    end
    goto(2);
    check("reset busy", busy[0], 1'b0);
    check("reset sen", sen[0], 1'b1);
    check("reset rd_data", rd_data[0], 16'h0000);
    goto(3);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    goto(5);

    // Single write with readback and an overrun attempt mid-frame.
    send(0, 16'h005A, 16'h1234, {8'hC3, 16'hBEEF}, n);
    check("t1 sen low at N+1", sen[0], 1'b0);
    check("t1 busy at N+1", busy[0], 1'b1);
    goto(n + 50);
    send(0, 16'h0011, 16'hFFFF, 24'h0, dummy);
    check("t3 overrun at N+51", overrun[0], 1'b1);
    goto(n + 52);
    check("t3 overrun cleared", overrun[0], 1'b0);
    goto(n + 196);
    check("t1 sen low at N+196", sen[0], 1'b0);
    goto(n + 197);
    check("t1 sen high at N+197", sen[0], 1'b1);
    goto(n + 200);
    check("t1 no done at N+200", done[0], 1'b0);
    goto(n + 201);
    check("t1 done at N+201", done[0], 1'b1);
    check("t1 busy low at N+201", busy[0], 1'b0);
    check("t1 frame on wire", rx[0], 24'h5A1234);
    check("t1 sclk rises", rises[0], 24);
    check("t2 rd_data", rd_data[0], 16'hBEEF);
    goto(n + 230);
    check("t3 no second frame", sen[0], 1'b1);
    check("t2 rd_data stable", rd_data[0], 16'hBEEF);

    // Back-to-back: second request lands in the done cycle.
    send(0, 16'($urandom), 16'($urandom), 24'($urandom), m);
    goto(m + flen(0));
    check("t4 done before b2b", done[0], 1'b1);
    send(0, 16'h0001, 16'h0002, 24'h00A5A5, n2);
    check("t4 sen falls next cycle", sen[0], 1'b0);
    goto(n2 + flen(0));
    check("t4 second frame", rx[0], 24'h010002);
    check("t4 second rd_data", rd_data[0], 16'hA5A5);

    // Reset mid-shift, with a request concurrent with reset.
    send(0, 16'h00C3, 16'h9876, 24'h123456, q);
    goto(q + 100);
    rst_n[0]    = 1'b0;
    wr_req[0]   = 1'b1;
    reg_addr[0] = 16'h0077;
    goto(q + 101);
    rst_n[0]  = 1'b1;
    wr_req[0] = 1'b0;
    check("t5 sen after reset", sen[0], 1'b1);
    check("t5 sclk after reset", sclk[0], 1'b0);
    check("t5 busy after reset", busy[0], 1'b0);
    check("t5 rd_data after reset", rd_data[0], 16'h0000);
    goto(q + 210);
    send(0, 16'h0033, 16'h4455, 24'h00CAFE, n);
    goto(n + flen(0));
    check("t5 fresh frame done", done[0], 1'b1);
    check("t5 fresh frame wire", rx[0], 24'h334455);

    random_frames(0, 6);

    // Minimum timing instance.
    goto(cyc + 2);
    send(1, 16'h00A5, 16'h5A5A, 24'h00F00D, f);
    goto(f + 51);
    check("t6 no done at N+51", done[1], 1'b0);
    goto(f + 52);
    check("t6 done at N+52", done[1], 1'b1);
    check("t6 frame on wire", rx[1], 24'hA55A5A);
    check("t6 rd_data", rd_data[1], 16'hF00D);
    random_frames(1, 8);
    goto(cyc + 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
